alu_core: RTL and testbench



---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_divider.sv | 84 ++++++++
 rtl/alu_core.sv | 179 +++++++++++++++++
 tb/tb_alu_core.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU core.
//   alu_op_e     - 4-bit opcode encoding (13..15 are illegal)
//   alu_state_e  - control FSM states of alu_core
//   FLAG_*       - bit positions of the status flags in the packed flag vector
//   is_div_op()  - true for the opcodes that use the iterative divider
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_NOTA = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_EQ   = 4'd10,
    OP_NOTB = 4'd11,
    OP_REM  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } alu_state_e;

  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_CARRY   = 1;
  localparam int FLAG_OVF     = 2;
  localparam int FLAG_DBZ     = 3;
  localparam int FLAG_ILLEGAL = 4;
  localparam int NUM_FLAGS    = 5;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative restoring unsigned divider, one quotient bit per cycle.
//   clk, rst_n         - clock, asynchronous active-low reset (abandons any division)
//   start              - load dividend/divisor; the first iteration happens on this edge
//   dividend, divisor  - W-bit unsigned operands (divisor must be non-zero)
//   done               - one-cycle pulse, quotient/remainder valid while high
//   quotient, remainder- W-bit results
// The start edge performs iteration 1 and the following W-1 edges the rest,
// so done is high in the cycle after the W-th iteration edge.
module alu_divider
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  rem_reg;
  logic [W-1:0]  dq_reg;      // dividend bits shift out the top, quotient bits shift in
  logic [W-1:0]  div_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [W-1:0]  src_rem;
  logic [W-1:0]  src_dq;
  logic [W-1:0]  src_div;
  logic [W:0]    partial;
  logic          ge;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  dq_next;

  // On the start edge the step works on the fresh operands instead of the registers.
  assign src_rem = start ? '0       : rem_reg;
  assign src_dq  = start ? dividend : dq_reg;
  assign src_div = start ? divisor  : div_reg;

  assign partial = {src_rem, src_dq[W-1]};
  assign ge      = partial >= {1'b0, src_div};
  // When ge holds, partial - divisor < divisor, so the low W bits are exact.
  assign rem_next = ge ? (partial[W-1:0] - src_div) : partial[W-1:0];
  assign dq_next  = {src_dq[W-2:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      dq_reg   <= '0;
      div_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg  <= rem_next;
        dq_reg   <= dq_next;
        div_reg  <= divisor;
        cnt_reg  <= CW'(1);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        rem_reg <= rem_next;
        dq_reg  <= dq_next;
        cnt_reg <= cnt_reg + CW'(1);
        if (cnt_reg == CW'(W - 1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done      = done_reg;
  assign quotient  = dq_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/alu_core.sv
// alu_core: valid/ready ALU with single-cycle ops and an iterative divider.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - request handshake; in_op, in_a, in_b captured on accept
//   out_valid/out_ready   - result handshake; outputs held stable while stalled
//   out_result            - primary result
//   out_result_hi         - upper product half (MUL), remainder (DIV), else 0
//   out_zero/carry/ovf/dbz/illegal - status flags qualified by out_valid
// Non-divide ops (and divide by zero) are computed combinationally and
// registered on the accepting edge. DIV/REM with a non-zero divisor run the
// divider for W cycles in DIV_BUSY before moving to HOLD.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [W-1:0] out_result_hi,
  output logic         out_zero,
  output logic         out_carry,
  output logic         out_ovf,
  output logic         out_dbz,
  output logic         out_illegal
);

  localparam int S = $clog2(W);

  alu_state_e           state_reg, state_next;
  logic [W-1:0]         result_reg, result_hi_reg;
  logic [NUM_FLAGS-1:0] flags_reg;
  logic                 rem_sel_reg;   // in-flight division is REM rather than DIV

  logic                 accept;
  logic                 div_start;
  logic                 load_direct;

  logic [W:0]           sum_w, dif_w;
  logic [2*W-1:0]       prod_w;
  logic [W:0]           shl_w, shr_w;
  logic [W-1:0]         res_c, hi_c;
  logic [NUM_FLAGS-1:0] flags_c;

  logic                 div_done;
  logic [W-1:0]         div_quo, div_rem;
  logic [W-1:0]         dres_c, dhi_c;

  assign out_valid = (state_reg == ST_HOLD);
  assign in_ready  = rst_n && (state_reg != ST_DIV_BUSY) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && is_div_op(in_op) && (in_b != '0);
  assign load_direct = accept && !div_start;

  assign sum_w  = {1'b0, in_a} + {1'b0, in_b};
  assign dif_w  = {1'b0, in_a} - {1'b0, in_b};
  assign prod_w = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
  // The extra bit catches the last bit shifted out (stays 0 for amount 0).
  assign shl_w  = {1'b0, in_a} << in_b[S-1:0];
  assign shr_w  = {in_a, 1'b0} >> in_b[S-1:0];

  always_comb begin
    res_c   = '0;
    hi_c    = '0;
    flags_c = '0;
    case (in_op)
      OP_ADD: begin
        res_c                = sum_w[W-1:0];
        flags_c[FLAG_CARRY]  = sum_w[W];
        flags_c[FLAG_OVF]    = (in_a[W-1] == in_b[W-1]) && (sum_w[W-1] != in_a[W-1]);
      end
      OP_SUB: begin
        res_c                = dif_w[W-1:0];
        flags_c[FLAG_CARRY]  = dif_w[W];    // borrow: a < b
        flags_c[FLAG_OVF]    = (in_a[W-1] != in_b[W-1]) && (dif_w[W-1] != in_a[W-1]);
      end
      OP_MUL: begin
        res_c               = prod_w[W-1:0];
        hi_c                = prod_w[2*W-1:W];
        flags_c[FLAG_CARRY] = (prod_w[2*W-1:W] != '0);
      end
      // Divide ops only reach the registers here when in_b == 0.
      OP_DIV: begin
        res_c             = '1;
        hi_c              = in_a;
        flags_c[FLAG_DBZ] = 1'b1;
      end
      OP_REM: begin
        res_c             = in_a;
        flags_c[FLAG_DBZ] = 1'b1;
      end
      OP_AND:  res_c = in_a & in_b;
      OP_OR:   res_c = in_a | in_b;
      OP_XOR:  res_c = in_a ^ in_b;
      OP_NOTA: res_c = ~in_a;
      OP_NOTB: res_c = ~in_b;
      OP_EQ:   res_c = {{(W-1){1'b0}}, (in_a == in_b)};
      OP_SHL: begin
        res_c               = shl_w[W-1:0];
        flags_c[FLAG_CARRY] = shl_w[W];
      end
      OP_SHR: begin
        res_c               = shr_w[W:1];
        flags_c[FLAG_CARRY] = shr_w[0];
      end
      default: flags_c[FLAG_ILLEGAL] = 1'b1;
    endcase
    flags_c[FLAG_ZERO] = (res_c == '0);
  end

  alu_divider #(.W(W)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (in_a),
    .divisor   (in_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign dres_c = rem_sel_reg ? div_rem : div_quo;
  assign dhi_c  = rem_sel_reg ? '0      : div_rem;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = div_start ? ST_DIV_BUSY : ST_HOLD;
      end
      ST_DIV_BUSY: begin
        if (div_done) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (accept)         state_next = div_start ? ST_DIV_BUSY : ST_HOLD;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      result_reg    <= '0;
      result_hi_reg <= '0;
      flags_reg     <= '0;
      rem_sel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (div_start) rem_sel_reg <= (in_op == OP_REM);
      if (load_direct) begin
        result_reg    <= res_c;
        result_hi_reg <= hi_c;
        flags_reg     <= flags_c;
      end else if (div_done) begin
        result_reg          <= dres_c;
        result_hi_reg       <= dhi_c;
        flags_reg           <= '0;
        flags_reg[FLAG_ZERO] <= (dres_c == '0);
      end
    end
  end

  assign out_result    = result_reg;
  assign out_result_hi = result_hi_reg;
  assign out_zero      = flags_reg[FLAG_ZERO];
  assign out_carry     = flags_reg[FLAG_CARRY];
  assign out_ovf       = flags_reg[FLAG_OVF];
  assign out_dbz       = flags_reg[FLAG_DBZ];
  assign out_illegal   = flags_reg[FLAG_ILLEGAL];

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors for alu_core (W=8) checked against an
// arithmetic reference model; a negedge monitor checks every delivered result,
// latency, stall stability and in_ready. Latency counts the accepting edge as
// edge 1, so a single-cycle op is visible right after the accepting edge.
module tb_alu_core;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a, in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result, out_result_hi;
  logic         out_zero, out_carry, out_ovf, out_dbz, out_illegal;

  alu_core #(.W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_result_hi (out_result_hi),
    .out_zero      (out_zero),
    .out_carry     (out_carry),
    .out_ovf       (out_ovf),
    .out_dbz       (out_dbz),
    .out_illegal   (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {result, result_hi, zero, carry, ovf, dbz, illegal}
  logic [20:0] got;
  assign got = {out_result, out_result_hi, out_zero, out_carry, out_ovf, out_dbz, out_illegal};

  typedef struct {
    logic [20:0] exp;
    bit          lit;
    logic [20:0] lexp;
    int          acc;
    int          lat;
    bit          seen;
  } txn_t;
  txn_t q[$];

  bit          lit_en;
  logic [20:0] lit_exp;
  bit          hold_prev;
  logic [20:0] snap;

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, g, e, $time);
    end
  endtask

  function automatic logic [20:0] model(input logic [3:0] op, input logic [7:0] a8, input logic [7:0] b8);
    int a, b, r, h, s, sa, sb, n;
    bit z, c, o, d, il;
    a = int'(a8); b = int'(b8);
    r = 0; h = 0; c = 0; o = 0; d = 0; il = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (int'(op))
      0: begin s = a + b; r = s % 256; c = (s > 255); o = (sa + sb > 127) || (sa + sb < -128); end
      1: begin r = (a - b + 256) % 256; c = (a < b); o = (sa - sb > 127) || (sa - sb < -128); end
      2: begin s = a * b; r = s % 256; h = s / 256; c = (h != 0); end
      3: if (b == 0) begin r = 255; h = a; d = 1; end else begin r = a / b; h = a % b; end
      12: if (b == 0) begin r = a; d = 1; end else r = a % b;
      4: r = a & b;
      5: r = a | b;
      6: r = 255 - a;
      7: r = a ^ b;
      8: begin n = b % 8; r = (a << n) % 256; c = (n != 0) ? (((a >> (8 - n)) & 1) != 0) : 0; end
      9: begin n = b % 8; r = a >> n; c = (n != 0) ? (((a >> (n - 1)) & 1) != 0) : 0; end
      10: r = (a == b) ? 1 : 0;
      11: r = 255 - b;
      default: il = 1;
    endcase
    z = (r == 0);
    return {8'(r), 8'(h), z, c, o, d, il};
  endfunction

  // Monitor: one pass per cycle at the falling edge.
  always @(negedge clk) begin
    txn_t t;
    bit exp_rdy;
    if (!rst_n) begin
      chk("reset_outputs", 32'({out_valid, got}), 32'd0);
      q.delete();
      hold_prev = 0;
    end else begin
      if (hold_prev)
        chk("stall_stable", 32'({out_valid, got}), 32'({1'b1, snap}));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!q[0].seen) begin
            q[0].seen = 1;
            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          end
        end
      end
      exp_rdy = !(q.size() > 0 && !q[0].seen) && (!out_valid || out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (out_valid && out_ready && q.size() > 0) begin
        chk("result_model", 32'(got), 32'(q[0].exp));
        if (q[0].lit) chk("result_literal", 32'(got), 32'(q[0].lexp));
        void'(q.pop_front());
      end
      if (q.size() > 0 && !q[0].seen && (cyc - q[0].acc > W + 4)) begin
        chk("result_timeout", 32'(0), 32'(1));
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        t.exp  = model(in_op, in_a, in_b);
        t.lit  = lit_en;
        t.lexp = lit_exp;
        t.acc  = cyc;
        t.lat  = ((in_op == 4'd3 || in_op == 4'd12) && in_b != 0) ? W + 1 : 1;
        t.seen = 0;
        q.push_back(t);
      end
      hold_prev = out_valid && !out_ready;
      snap      = got;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit lit, input logic [7:0] er, input logic [7:0] eh, input logic [4:0] ef);
    bit ok;
    in_op = op; in_a = a; in_b = b;
    lit_en = lit; lit_exp = {er, eh, ef};
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lit_en = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b1; lit_en = 0; lit_exp = '0; hold_prev = 0; snap = '0;
    #2;
    chk("reset_async", 32'({out_valid, got}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    //    op     a      b      lit res    hi     {z,c,o,d,il}
    send(4'd0,  8'hF0, 8'h20, 1, 8'h10, 8'h00, 5'b01000);
    send(4'd1,  8'h7F, 8'hFF, 1, 8'h80, 8'h00, 5'b01100);
    send(4'd2,  8'hFF, 8'hFF, 1, 8'h01, 8'hFE, 5'b01000);
    send(4'd3,  8'd200, 8'd7, 1, 8'd28, 8'd4,  5'b00000);
    send(4'd3,  8'h05, 8'h00, 1, 8'hFF, 8'h05, 5'b00010);
    send(4'd14, 8'h12, 8'h34, 1, 8'h00, 8'h00, 5'b10001);
    send(4'd12, 8'd200, 8'd7, 1, 8'd4,  8'd0,  5'b00000);
    send(4'd12, 8'h09, 8'h00, 1, 8'h09, 8'h00, 5'b00010);
    send(4'd8,  8'h81, 8'h01, 1, 8'h02, 8'h00, 5'b01000);
    send(4'd9,  8'h81, 8'h01, 1, 8'h40, 8'h00, 5'b01000);
    send(4'd8,  8'h81, 8'h00, 1, 8'h81, 8'h00, 5'b00000);
    send(4'd9,  8'h81, 8'h09, 1, 8'h40, 8'h00, 5'b01000);
    send(4'd10, 8'h05, 8'h05, 1, 8'h01, 8'h00, 5'b00000);
    send(4'd6,  8'h0F, 8'h33, 1, 8'hF0, 8'h00, 5'b00000);
    send(4'd11, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 5'b10000);
    send(4'd4,  8'hF0, 8'h3C, 1, 8'h30, 8'h00, 5'b00000);
    send(4'd5,  8'hF0, 8'h0F, 1, 8'hFF, 8'h00, 5'b00000);
    send(4'd7,  8'hAA, 8'hAA, 1, 8'h00, 8'h00, 5'b10000);
    send(4'd0,  8'h80, 8'h80, 1, 8'h00, 8'h00, 5'b11100);
    send(4'd1,  8'h05, 8'h05, 1, 8'h00, 8'h00, 5'b10000);
    drain();

    // Consumer stall for 5 cycles after an ADD.
    out_ready = 1'b0;
    send(4'd0, 8'h11, 8'h22, 1, 8'h33, 8'h00, 5'b00000);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Back-to-back ADDs: must be accepted on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      in_op = 4'd0; in_a = 8'(i * 40 + 1); in_b = 8'(i + 2); in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a division.
    send(4'd3, 8'd200, 8'd7, 0, 8'h00, 8'h00, 5'b00000);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("mid_div_reset", 32'({out_valid, got}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1;
    send(4'd0, 8'h03, 8'h04, 1, 8'h07, 8'h00, 5'b00000);
    drain();

    // Pseudo-random sweep checked by the model only.
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom),
           ((i % 5) == 0) ? 8'h00 : 8'($urandom), 0, 8'h00, 8'h00, 5'b00000);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
